// File: rtl/branch_resolve_unit.sv
// Branch resolution for the EX stage: compare-select decode, taken decision,
// registered PC redirect / flush sequencing and saturating branch statistics.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             ex_branch,
   input  logic             ex_jump,
   input  logic [2:0]       ex_funct3,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             ex_stall,
   input  logic             BrEq,
   input  logic             BrLt,
   input  logic             cnt_clr,
   output logic             BrUn,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush,
   output logic             misalign_exc,
   output logic             illegal_br,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      EXC      = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

   logic resolve;
   logic cond_taken;
   logic is_illegal;
   logic taken;
   logic br_inc;
   logic taken_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign BrUn = ex_funct3[2] & ex_funct3[1];

   always_comb begin
      cond_taken = 1'b0;
      case (ex_funct3)
         3'b000:         cond_taken = BrEq;
         3'b001:         cond_taken = ~BrEq;
         3'b100, 3'b110: cond_taken = BrLt;
         3'b101, 3'b111: cond_taken = ~BrLt;
         default:        cond_taken = 1'b0;
      endcase
   end

   assign is_illegal = (ex_funct3[2:1] == 2'b01);
   // Wrong-path instructions behind a redirect or exception never resolve.
   assign resolve    = ex_valid & (ex_branch | ex_jump) & ~ex_stall & (state_q == IDLE);
   assign taken      = ex_jump | (ex_branch & cond_taken);
   assign br_inc     = resolve & ex_branch & ~ex_jump;
   assign taken_inc  = br_inc & cond_taken;

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      illegal_d     = br_inc & is_illegal;
      case (state_q)
         IDLE: begin
            if (resolve && taken) begin
               if (ex_target[1:0] == 2'b00) begin
                  state_d       = REDIRECT;
                  redirect_pc_d = ex_target;
               end else begin
                  state_d = EXC;
               end
            end
         end
         REDIRECT: if (!ex_stall) state_d = IDLE;
         EXC:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      if (cnt_clr) begin
         br_cnt_d    = '0;
         taken_cnt_d = '0;
      end else begin
         if (br_inc)    br_cnt_d    = sat_inc(br_cnt_q);
         if (taken_inc) taken_cnt_d = sat_inc(taken_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         redirect_pc_q <= '0;
         illegal_q     <= 1'b0;
         br_cnt_q      <= '0;
         taken_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         illegal_q     <= illegal_d;
         br_cnt_q      <= br_cnt_d;
         taken_cnt_q   <= taken_cnt_d;
      end
   end

   // Outputs decode straight from the state register, so reset clears them at once.
   assign redirect_valid = (state_q == REDIRECT);
   assign misalign_exc   = (state_q == EXC);
   assign flush          = (state_q != IDLE);
   assign redirect_pc    = redirect_pc_q;
   assign illegal_br     = illegal_q;
   assign br_cnt         = br_cnt_q;
   assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a table of single-branch vectors
// plus hand-written sequences for stall, back-to-back, saturation and reset.
module tb_branch_resolve_unit;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic             clk;
   logic             rst_n;
   logic             ex_valid, ex_branch, ex_jump, ex_stall;
   logic [2:0]       ex_funct3;
   logic [XLEN-1:0]  ex_target;
   logic             BrEq, BrLt, cnt_clr;
   logic             BrUn, redirect_valid, flush, misalign_exc, illegal_br;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] br_cnt, taken_cnt;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_funct3(ex_funct3), .ex_target(ex_target), .ex_stall(ex_stall),
      .BrEq(BrEq), .BrLt(BrLt), .cnt_clr(cnt_clr),
      .BrUn(BrUn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .misalign_exc(misalign_exc), .illegal_br(illegal_br),
      .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        br;
      logic        jmp;
      logic [2:0]  f3;
      logic        eq;
      logic        lt;
      logic [31:0] tgt;
      logic        e_brun;
      logic        e_redir;
      logic        e_exc;
      logic        e_ill;
      logic        e_brinc;
      logic        e_tkinc;
   } vec_t;

   vec_t tbl[15];
   int   nvec  = 0;
   int   nfail = 0;
   int   exp_br = 0;
   int   exp_tk = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bump(input logic b, input logic t);
      if (b && exp_br < CMAX) exp_br++;
      if (t && exp_tk < CMAX) exp_tk++;
   endtask

   task automatic drive(input logic br, input logic jmp, input logic [2:0] f3,
                        input logic eq, input logic lt, input logic [31:0] tgt);
      ex_valid  = 1'b1;
      ex_branch = br;
      ex_jump   = jmp;
      ex_funct3 = f3;
      BrEq      = eq;
      BrLt      = lt;
      ex_target = tgt;
   endtask

   task automatic idle_inputs();
      ex_valid  = 1'b0;
      ex_branch = 1'b0;
      ex_jump   = 1'b0;
   endtask

   task automatic check_cnts(input string tag);
      check({tag, " br_cnt"},    br_cnt,    exp_br);
      check({tag, " taken_cnt"}, taken_cnt, exp_tk);
   endtask

   initial begin
      tbl[0]  = '{H, L, 3'b000, H, L, 32'h0000_0100, L, H, L, L, H, H};
      tbl[1]  = '{H, L, 3'b000, L, H, 32'h0000_0104, L, L, L, L, H, L};
      tbl[2]  = '{H, L, 3'b001, L, L, 32'h0000_0200, L, H, L, L, H, H};
      tbl[3]  = '{H, L, 3'b001, H, L, 32'h0000_0204, L, L, L, L, H, L};
      tbl[4]  = '{H, L, 3'b100, L, H, 32'h0000_0308, L, H, L, L, H, H};
      tbl[5]  = '{H, L, 3'b101, L, H, 32'h0000_030C, L, L, L, L, H, L};
      tbl[6]  = '{H, L, 3'b110, H, L, 32'h0000_0400, H, L, L, L, H, L};
      tbl[7]  = '{H, L, 3'b111, L, H, 32'h0000_0404, H, L, L, L, H, L};
      tbl[8]  = '{H, L, 3'b111, L, L, 32'h0000_0408, H, H, L, L, H, H};
      tbl[9]  = '{H, L, 3'b010, H, H, 32'h0000_0500, L, L, L, H, H, L};
      tbl[10] = '{H, L, 3'b011, H, H, 32'h0000_0504, L, L, L, H, H, L};
      tbl[11] = '{L, H, 3'b000, L, L, 32'h0000_0102, L, L, H, L, L, L};
      tbl[12] = '{L, H, 3'b000, L, L, 32'h0000_2000, L, H, L, L, L, L};
      tbl[13] = '{H, H, 3'b001, H, L, 32'h0000_3000, L, H, L, L, L, L};
      tbl[14] = '{H, L, 3'b000, H, L, 32'h0000_0106, L, L, H, L, H, H};

      rst_n = 1'b0;
      idle_inputs();
      ex_stall  = 1'b0;
      ex_funct3 = 3'b000;
      ex_target = '0;
      BrEq = 1'b0;
      BrLt = 1'b0;
      cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      check("reset redirect_valid", redirect_valid, 0);
      check("reset flush",          flush,          0);
      check("reset misalign_exc",   misalign_exc,   0);
      check("reset illegal_br",     illegal_br,     0);
      check("reset redirect_pc",    redirect_pc,    0);
      check_cnts("reset");

      // Single-branch vectors, each started from IDLE
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].br, tbl[i].jmp, tbl[i].f3, tbl[i].eq, tbl[i].lt, tbl[i].tgt);
         #1;
         check($sformatf("v%0d BrUn", i), BrUn, tbl[i].e_brun);
         tick();
         idle_inputs();
         bump(tbl[i].e_brinc, tbl[i].e_tkinc);
         check($sformatf("v%0d redirect_valid", i), redirect_valid, tbl[i].e_redir);
         check($sformatf("v%0d flush", i), flush, tbl[i].e_redir | tbl[i].e_exc);
         check($sformatf("v%0d misalign_exc", i), misalign_exc, tbl[i].e_exc);
         check($sformatf("v%0d illegal_br", i), illegal_br, tbl[i].e_ill);
         if (tbl[i].e_redir)
            check($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].tgt);
         check_cnts($sformatf("v%0d", i));
         tick();
         check($sformatf("v%0d next redirect_valid", i), redirect_valid, 0);
         check($sformatf("v%0d next flush", i), flush, 0);
         check($sformatf("v%0d next misalign_exc", i), misalign_exc, 0);
         check($sformatf("v%0d next illegal_br", i), illegal_br, 0);
      end

      // Not-taken BGEU immediately followed by a taken BNE
      drive(H, L, 3'b111, L, H, 32'h0000_0600);
      #1 check("b2b BrUn", BrUn, 1);
      tick();
      bump(H, L);
      check("b2b nt redirect_valid", redirect_valid, 0);
      check("b2b nt flush", flush, 0);
      drive(H, L, 3'b001, L, L, 32'h0000_0604);
      tick();
      idle_inputs();
      bump(H, H);
      check("b2b taken redirect_valid", redirect_valid, 1);
      check("b2b taken redirect_pc", redirect_pc, 32'h0000_0604);
      check_cnts("b2b");
      tick();
      check("b2b end redirect_valid", redirect_valid, 0);

      // Taken BLT, then two stalled cycles and a shadow branch held in EX
      drive(H, L, 3'b100, L, H, 32'h0000_0800);
      tick();
      bump(H, H);
      drive(H, L, 3'b000, H, L, 32'h0000_0900);
      ex_stall = 1'b1;
      check("stall c1 redirect_valid", redirect_valid, 1);
      tick();
      check("stall c2 redirect_valid", redirect_valid, 1);
      check("stall c2 flush", flush, 1);
      tick();
      check("stall c3 redirect_valid", redirect_valid, 1);
      check("stall c3 redirect_pc", redirect_pc, 32'h0000_0800);
      ex_stall = 1'b0;
      tick();
      idle_inputs();
      check("stall end redirect_valid", redirect_valid, 0);
      check("stall end flush", flush, 0);
      check_cnts("stall shadow");

      // Saturation with 4-bit counters, then clear racing a taken branch
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      exp_br = 0;
      exp_tk = 0;
      check_cnts("clear");
      drive(H, L, 3'b000, L, L, 32'h0000_0A00);
      for (int k = 0; k < 17; k++) begin
         tick();
         bump(H, L);
      end
      idle_inputs();
      check_cnts("sat nt");
      for (int k = 0; k < 17; k++) begin
         drive(H, L, 3'b001, L, L, 32'h0000_0B00);
         tick();
         idle_inputs();
         bump(H, H);
         tick();
      end
      check_cnts("sat taken");
      drive(H, L, 3'b001, L, L, 32'h0000_0C00);
      cnt_clr = 1'b1;
      tick();
      idle_inputs();
      cnt_clr = 1'b0;
      exp_br = 0;
      exp_tk = 0;
      check_cnts("clr priority");
      check("clr priority redirect_valid", redirect_valid, 1);
      tick();

      // Asynchronous reset in the middle of a redirect
      drive(H, L, 3'b000, H, L, 32'h0000_0D00);
      tick();
      idle_inputs();
      check("pre-rst redirect_valid", redirect_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst redirect_valid", redirect_valid, 0);
      check("async rst flush", flush, 0);
      check("async rst redirect_pc", redirect_pc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_br = 0;
      exp_tk = 0;
      tick();
      check("post-rst redirect_valid", redirect_valid, 0);
      check("post-rst flush", flush, 0);
      check_cnts("post-rst");
      drive(H, L, 3'b000, L, L, 32'h0000_0E00);
      tick();
      idle_inputs();
      bump(H, L);
      check("post-rst resolve redirect_valid", redirect_valid, 0);
      check_cnts("post-rst resolve");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage consumer of the branch comparator flags. Drives the comparator's `BrUn` select from the instruction's funct3 and combines `BrEq`/`BrLt` into a taken/not-taken decision. Fetch uses static not-taken prediction, so on a taken branch or jump this block issues a registered PC redirect and a pipeline flush through a small state machine. It also keeps saturating branch statistics counters.

## Interface
Parameters:
- `XLEN`, 32: PC and target width.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX stage holds a valid instruction.
- `ex_branch`  in  1  instruction is a conditional branch.
- `ex_jump`  in  1  instruction is JAL/JALR.
- `ex_funct3`  in  3  branch funct3.
- `ex_target`  in  XLEN  branch/jump target from the EX adder.
- `ex_stall`  in  1  pipeline hold; the EX instruction does not advance this cycle.
- `BrEq`  in  1  comparator equal flag.
- `BrLt`  in  1  comparator less-than flag.
- `cnt_clr`  in  1  synchronous clear of the statistics counters.
- `BrUn`  out  1  combinational compare select: 1 when funct3 is 110 or 111, else 0.
- `redirect_valid`  out  1  fetch must load `redirect_pc`.
- `redirect_pc`  out  XLEN  registered redirect target.
- `flush`  out  1  kill IF/ID, ID/EX and the wrong-path instruction in EX.
- `misalign_exc`  out  1  taken target not 4-byte aligned.
- `illegal_br`  out  1  branch with funct3 010 or 011.
- `br_cnt`  out  CNT_W  count of resolved conditional branches.
- `taken_cnt`  out  CNT_W  count of taken conditional branches.

## Operation
- Resolve condition: `ex_valid & (ex_branch | ex_jump) & ~ex_stall & state==IDLE`.
- Taken decode:
  - BEQ 000 = BrEq.
  - BNE 001 = ~BrEq.
  - BLT 100 / BLTU 110 = BrLt.
  - BGE 101 / BGEU 111 = ~BrLt.
  - 010/011 are not taken and pulse `illegal_br` in the next cycle.
  - `ex_jump` is always taken and overrides `ex_branch`.
- FSM states:
  - IDLE: the only state in which branches resolve.
    - If resolved taken with `ex_target[1:0]==0`: go to REDIRECT and latch `redirect_pc=ex_target`.
    - If resolved taken with a misaligned target: go to EXC.
    - Otherwise stay in IDLE.
  - REDIRECT: `redirect_valid=1` and `flush=1`. Leave for IDLE on the first cycle with `ex_stall=0`; hold (redirect and flush stay high) while `ex_stall=1`.
  - EXC: `misalign_exc=1` and `flush=1` for exactly one cycle, `redirect_valid=0`, then IDLE. `ex_stall` is ignored here.
- In REDIRECT and EXC, EX-stage inputs are wrong-path: they are ignored and not counted.
- Counters:
  - `br_cnt` increments on every resolved `ex_branch` that is not a jump, including illegal funct3.
  - `taken_cnt` increments on every resolved taken conditional branch.
  - Both saturate at all-ones; `cnt_clr` takes priority over an increment in the same cycle.
- `BrUn` is purely combinational from `ex_funct3`, valid regardless of state.
- Reset values: state IDLE; `redirect_valid`, `flush`, `misalign_exc`, `illegal_br` are 0; `redirect_pc` is 0; both counters are 0.
- Reset asserted mid-REDIRECT aborts the redirect immediately (async); no redirect after release.

## Timing
- Decision in cycle N; `redirect_valid`/`flush` are high from cycle N+1 (registered, no combinational path from `BrEq`/`BrLt` to `redirect_valid`).
- Minimum redirect pulse is 1 cycle; it is extended 1:1 by `ex_stall` cycles.
- Back-to-back branches: a branch presented in the cycle after a taken resolution is shadow and is dropped. A not-taken resolution allows a new resolution in the next cycle.
- Counters update at the clock edge ending cycle N and are visible in N+1.
- `illegal_br` is a 1-cycle pulse in N+1.

## Test plan
- BEQ with BrEq=1, target 0x0000_0100 -> `BrUn`=0. Cycle N+1: `redirect_valid`=1, `redirect_pc`=0x100, `flush`=1. Cycle N+2: both 0. `br_cnt`=1, `taken_cnt`=1.
- BGEU with BrLt=1 -> `BrUn`=1, no redirect, `flush`=0. `br_cnt`=1, `taken_cnt`=0. A BNE with BrEq=0 in the next cycle resolves taken.
- Taken BLT in N with `ex_stall`=1 in N+1..N+2 -> redirect held for 3 cycles. Shadow branch inputs during those cycles leave the counters unchanged.
- JAL with target 0x0000_0102 -> `misalign_exc`=1 and `flush`=1 for one cycle, `redirect_valid`=0. Counters unchanged.
- Preload counters to all-ones via repeated taken branches with `CNT_W`=4 -> they stay at 0xF. `cnt_clr` together with a taken branch gives 0. funct3=010 -> `illegal_br` pulse, `br_cnt` increments, no redirect.
- Drop `rst_n` in REDIRECT -> `redirect_valid` and `flush` go to 0 asynchronously. After release, state is IDLE and counters are 0.
